// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD score/level/lines converters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

    // Nibble value the numeric display renders as an empty cell.
    localparam logic [3:0] BCD_BLANK = 4'hA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } conv_state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_dabble_adjust.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module bcd_dabble_adjust #(
    parameter int NIBBLES = 9
) (
    input  logic [4*NIBBLES-1:0] acc_dat,
    output logic [4*NIBBLES-1:0] adj_dat
);

    // Per-nibble add-3 so the following left shift carries correctly into the next digit.
    always_comb begin
        adj_dat = acc_dat;
        for (int i = 0; i < NIBBLES; i++) begin
            if (acc_dat[4*i +: 4] >= 4'd5) begin
                adj_dat[4*i +: 4] = acc_dat[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bcd_score_converter.sv
// Iterative binary-to-BCD converter for the score/level/lines display; saturates at all nines.
// Latency: done_out pulses BIN_WIDTH+2 edges after start_in is sampled (inclusive of the accept edge).
// Backpressure: start_in is ignored while busy_out is high; no queueing. Optional BCD_LEADING_BLANK_EN blanks leading zeros.
module bcd_score_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  sat_out,
    output logic [4*DIGITS-1:0]   bcd_out
);

    // One spare nibble on top of the displayed digits so values above the
    // display range still convert without wrapping before saturation.
    localparam int ACC_W = 4*DIGITS + 4;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [63:0]         MAX_DEC   = max_decimal(DIGITS);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [4*DIGITS-1:0] RESET_BCD = {{(DIGITS-1){BCD_BLANK}}, 4'h0};
`else
    localparam logic [4*DIGITS-1:0] RESET_BCD = '0;
`endif

    conv_state_t           state_q;
    logic [BIN_WIDTH-1:0]  shift_q;
    logic [ACC_W-1:0]      acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ACC_W-1:0]      adj;
    logic [4*DIGITS-1:0]   acc_fmt;
    logic                  over_max;
    logic                  unused_carry;

    bcd_dabble_adjust #(
        .NIBBLES (DIGITS + 1)
    ) u_adjust (
        .acc_dat (acc_q),
        .adj_dat (adj)
    );

    // The top adjusted bit is shifted out and can never be set for in-range widths.
    assign unused_carry = adj[ACC_W-1];

    // shift_q rotates rather than shifts, so after BIN_WIDTH steps it again
    // holds the captured value and doubles as the latched binary for this compare.
    assign over_max = ({{(64-BIN_WIDTH){1'b0}}, shift_q} > MAX_DEC);

    // Output formatting of the finished accumulator (leading-zero blanking when enabled).
    always_comb begin
`ifdef BCD_LEADING_BLANK_EN
        logic lead;
        lead    = 1'b1;
        acc_fmt = acc_q[4*DIGITS-1:0];
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (acc_q[4*i +: 4] == 4'h0)) begin
                acc_fmt[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
`else
        acc_fmt = acc_q[4*DIGITS-1:0];
`endif
    end

    // Control FSM: accept, count BIN_WIDTH shift steps, finish with a one-cycle done pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        cnt_q    <= '0;
                        busy_out <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath: capture the input on accept, then adjust-and-shift one bit per edge, MSB first.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift_q <= '0;
            acc_q   <= '0;
        end else if (state_q == IDLE && start_in) begin
            shift_q <= bin_in;
            acc_q   <= '0;
        end else if (state_q == SHIFT) begin
            acc_q   <= {adj[ACC_W-2:0], shift_q[BIN_WIDTH-1]};
            shift_q <= {shift_q[BIN_WIDTH-2:0], shift_q[BIN_WIDTH-1]};
        end
    end

    // Display-facing registers update only at the finish edge, so the reader never sees partial results.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bcd_out <= RESET_BCD;
            sat_out <= 1'b0;
        end else if (state_q == FINISH) begin
            if (over_max) begin
                bcd_out <= ALL_NINES;
                sat_out <= 1'b1;
            end else begin
                bcd_out <= acc_fmt;
                sat_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_converter.sv
// Directed self-checking bench for bcd_score_converter (default 27-bit, 8-digit build).
// Latency: checks done_out 29 edges after the edge on which start_in is driven.
// Backpressure: exercises ignored starts while busy, back-to-back starts and mid-conversion reset.
module tb_bcd_score_converter;

    localparam int BW = 27;
    localparam int DG = 8;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [31:0] E_RST    = 32'hAAAA_AAA0;
    localparam logic [31:0] E_1234   = 32'hAAAA_1234;
    localparam logic [31:0] E_0      = 32'hAAAA_AAA0;
    localparam logic [31:0] E_5      = 32'hAAAA_AAA5;
    localparam logic [31:0] E_42     = 32'hAAAA_AA42;
    localparam logic [31:0] E_5555   = 32'hAAAA_5555;
    localparam logic [31:0] E_987654 = 32'hAA98_7654;
    localparam logic [31:0] E_8      = 32'hAAAA_AAA8;
`else
    localparam logic [31:0] E_RST    = 32'h0000_0000;
    localparam logic [31:0] E_1234   = 32'h0000_1234;
    localparam logic [31:0] E_0      = 32'h0000_0000;
    localparam logic [31:0] E_5      = 32'h0000_0005;
    localparam logic [31:0] E_42     = 32'h0000_0042;
    localparam logic [31:0] E_5555   = 32'h0000_5555;
    localparam logic [31:0] E_987654 = 32'h0098_7654;
    localparam logic [31:0] E_8      = 32'h0000_0008;
`endif
    localparam logic [31:0] E_NINES  = 32'h9999_9999;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          start_in;
    logic [BW-1:0] bin_in;
    logic          busy_out;
    logic          done_out;
    logic          sat_out;
    logic [31:0]   bcd_out;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int pulses;
    int edges;
    bit got_done;

    bcd_score_converter #(
        .BIN_WIDTH (BW),
        .DIGITS    (DG)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (start_in),
        .bin_in   (bin_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .sat_out  (sat_out),
        .bcd_out  (bcd_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge. Drives start with v, optionally injects a
    // second start (inj_v) while busy, and returns the edge count until done_out.
    task automatic convert(input logic [BW-1:0] v, input int inj_at,
                           input logic [BW-1:0] inj_v, output int n_edges);
        start_in = 1'b1;
        bin_in   = v;
        n_edges  = 0;
        while (n_edges < 100) begin
            @(posedge clk_in);
            n_edges++;
            #1;
            if (n_edges == 1) begin
                start_in = 1'b0;
                check("busy_after_accept", busy_out, 1);
            end
            if (inj_at != 0 && n_edges == inj_at) begin
                start_in = 1'b1;
                bin_in   = inj_v;
            end
            if (inj_at != 0 && n_edges == inj_at + 1) start_in = 1'b0;
            if (done_out) break;
        end
    endtask

    // Counts done pulses over n cycles; called #1 after an edge.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
            if (done_out) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        start_in = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_sat",  sat_out,  0);
        check("rst_bcd",  bcd_out,  E_RST);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Basic conversion and latency
        convert(27'd1234, 0, '0, lat);
        check("lat_1234", lat, 29);
        check("bcd_1234", bcd_out, E_1234);
        check("sat_1234", sat_out, 0);
        check("busy_in_done_cycle", busy_out, 0);
        @(posedge clk_in);
        #1;
        check("done_one_cycle", done_out, 0);
        check("bcd_1234_held", bcd_out, E_1234);

        // Zero, then max in-range value started in the done cycle
        @(posedge clk_in);
        #1;
        convert(27'd0, 0, '0, lat);
        check("lat_0", lat, 29);
        check("bcd_0", bcd_out, E_0);
        check("sat_0", sat_out, 0);
        convert(27'd99_999_999, 0, '0, lat);
        check("lat_b2b", lat, 29);
        check("bcd_99999999", bcd_out, E_NINES);
        check("sat_99999999", sat_out, 0);

        // Saturation, then recovery
        @(posedge clk_in);
        #1;
        convert(27'd134_217_727, 0, '0, lat);
        check("lat_sat", lat, 29);
        check("bcd_sat", bcd_out, E_NINES);
        check("sat_flag", sat_out, 1);
        @(posedge clk_in);
        #1;
        convert(27'd5, 0, '0, lat);
        check("bcd_5", bcd_out, E_5);
        check("sat_5", sat_out, 0);

        // Start while busy is ignored
        @(posedge clk_in);
        #1;
        convert(27'd42, 10, 27'd77, lat);
        check("lat_42", lat, 29);
        check("bcd_42", bcd_out, E_42);
        count_done(40, pulses);
        check("no_queued_start", pulses, 0);
        check("bcd_42_held", bcd_out, E_42);

        // Reset in mid-conversion
        start_in = 1'b1;
        bin_in   = 27'd5555;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk_in);
            #1;
            if (i == 1) start_in = 1'b0;
        end
        rst_n_in = 1'b0;
        #1;
        check("abort_busy", busy_out, 0);
        check("abort_done", done_out, 0);
        check("abort_sat",  sat_out,  0);
        check("abort_bcd",  bcd_out,  E_RST);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        count_done(40, pulses);
        check("abort_no_done", pulses, 0);
        convert(27'd5555, 0, '0, lat);
        check("lat_5555", lat, 29);
        check("bcd_5555", bcd_out, E_5555);

        // Output stability during a conversion
        @(posedge clk_in);
        #1;
        convert(27'd987_654, 0, '0, lat);
        check("bcd_987654", bcd_out, E_987654);
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        start_in = 1'b1;
        bin_in   = 27'd8;
        edges    = 0;
        got_done = 1'b0;
        while (edges < 100 && !got_done) begin
            @(posedge clk_in);
            edges++;
            #1;
            if (edges == 1) start_in = 1'b0;
            if (edges == 5) bin_in = 27'd12345;
            if (done_out) begin
                check("bcd_new_8", bcd_out, E_8);
                got_done = 1'b1;
            end else begin
                check("bcd_hold_987654", bcd_out, E_987654);
            end
        end
        check("lat_8", edges, 29);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
